// File: rtl/ps2_scancode_sequencer.sv
// ps2_scancode_sequencer
//   Turns the PS/2 Set-2 byte stream into single key events and queues them.
//   E0 (extended), F0 (break) and E1 (Pause) prefixes are folded into one event.
//   Fake-shift codes and receiver filler bytes are dropped. A prefix sequence
//   that stalls between bytes is aborted with a seq_err pulse.
//
// Ports
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, qualified by rx_strb
//   rx_strb    one-cycle strobe per received byte
//   key_code   head event scan code (E1 means Pause), 0 while key_valid=0
//   key_ext    head event carried an E0 prefix, 0 while key_valid=0
//   key_break  head event is a release, 0 while key_valid=0
//   key_valid  event FIFO not empty
//   key_ready  consumer takes the head when key_valid & key_ready
//   overflow   sticky: an event was dropped because the FIFO was full
//   seq_err    one-cycle pulse: sequence aborted (timeout or illegal prefix)

module ps2_scancode_sequencer #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_strb,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow,
   output logic       seq_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_F0 = 8'hF0;
   localparam logic [7:0] B_E1 = 8'hE1;
   localparam logic [7:0] B_FAKE_SHIFT = 8'h12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0,
      S_PAUSE
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
   logic [2:0]      r_pcnt, w_pcnt_nxt;
   logic            r_seq_err, w_err;

   // Event produced by the byte in this cycle: {code, ext, brk}
   logic            w_push;
   logic [7:0]      w_ev_code;
   logic            w_ev_ext;
   logic            w_ev_brk;

   logic            w_filler;
   logic            w_prefix;

   // Receiver status/filler bytes that never form an event on their own
   assign w_filler = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                     (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);
   assign w_prefix = (rx_data == B_E0) || (rx_data == B_F0) || (rx_data == B_E1);

   //------------------------------------------------------------------------
   // Sequencer FSM
   //------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_tcnt    <= '0;
         r_pcnt    <= '0;
         r_seq_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tcnt    <= w_tcnt_nxt;
         r_pcnt    <= w_pcnt_nxt;
         r_seq_err <= w_err;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_pcnt_nxt  = r_pcnt;
      w_err       = 1'b0;
      w_push      = 1'b0;
      w_ev_code   = rx_data;
      w_ev_ext    = 1'b0;
      w_ev_brk    = 1'b0;

      if (rx_strb) begin
         // A byte always wins over a coinciding timeout
         w_tcnt_nxt = '0;
         case (r_state)
            S_IDLE: begin
               if (rx_data == B_E0) begin
                  w_state_nxt = S_E0;
               end else if (rx_data == B_F0) begin
                  w_state_nxt = S_F0;
               end else if (rx_data == B_E1) begin
                  w_state_nxt = S_PAUSE;
                  w_pcnt_nxt  = 3'd7;
               end else if (!w_filler) begin
                  w_push = 1'b1;
               end
            end
            S_E0: begin
               if (rx_data == B_F0) begin
                  w_state_nxt = S_E0F0;
               end else if (rx_data == B_E0) begin
                  w_state_nxt = S_E0;
               end else if (rx_data == B_E1) begin
                  w_err       = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (rx_data == B_FAKE_SHIFT) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_push      = 1'b1;
                  w_ev_ext    = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_F0: begin
               w_state_nxt = S_IDLE;
               if (w_prefix) begin
                  w_err = 1'b1;
               end else begin
                  w_push   = 1'b1;
                  w_ev_brk = 1'b1;
               end
            end
            S_E0F0: begin
               w_state_nxt = S_IDLE;
               if (w_prefix) begin
                  w_err = 1'b1;
               end else if (rx_data != B_FAKE_SHIFT) begin
                  w_push   = 1'b1;
                  w_ev_ext = 1'b1;
                  w_ev_brk = 1'b1;
               end
            end
            S_PAUSE: begin
               // Pause body bytes are counted, not inspected
               w_pcnt_nxt = r_pcnt - 3'd1;
               if (r_pcnt == 3'd1) begin
                  w_push      = 1'b1;
                  w_ev_code   = B_E1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end else if (r_state != S_IDLE) begin
         if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = S_IDLE;
            w_tcnt_nxt  = '0;
            w_err       = 1'b1;
         end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
         end
      end
   end

   assign seq_err = r_seq_err;

   //------------------------------------------------------------------------
   // Event FIFO
   //------------------------------------------------------------------------
   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          w_empty, w_full, w_pop, w_wr;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_pop   = !w_empty && key_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts
   assign w_wr    = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= {w_ev_code, w_ev_ext, w_ev_brk};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_wr && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_wr && w_pop) begin
            r_count <= r_count - CW'(1);
         end
         if (w_push && !w_wr) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign key_valid = !w_empty;
   assign overflow  = r_overflow;
   assign key_code  = w_empty ? 8'h00 : r_mem[r_rptr][9:2];
   assign key_ext   = w_empty ? 1'b0  : r_mem[r_rptr][1];
   assign key_break = w_empty ? 1'b0  : r_mem[r_rptr][0];

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Bench for ps2_scancode_sequencer: directed byte streams, a sequence-level
// reference model with a queue-based FIFO, and literal spot checks.

module tb_ps2_scancode_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TO    = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_strb = 1'b0;
   logic       key_ready = 1'b0;
   logic [7:0] key_code;
   logic       key_ext, key_break, key_valid, overflow, seq_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ps2_scancode_sequencer #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_strb   (rx_strb),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_break (key_break),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .overflow  (overflow),
      .seq_err   (seq_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   //------------------------------------------------------------------------
   // Reference model: keeps the bytes of the pending sequence and judges the
   // whole sequence each time a byte arrives.
   //------------------------------------------------------------------------
   logic [7:0] m_seq[$];
   logic [9:0] m_q[$];
   int         m_gap = 0;
   logic       m_ovf = 1'b0;
   logic       m_err = 1'b0;

   function automatic bit is_pre(input logic [7:0] b);
      return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
   endfunction

   // kind: 0 incomplete, 1 dropped, 2 error, 3 event in ev
   function automatic void classify(output int kind, output logic [9:0] ev);
      int n;
      int lead;
      logic [7:0] last;
      n    = m_seq.size();
      last = m_seq[n-1];
      ev   = '0;
      kind = 0;
      lead = 0;
      while (lead < n - 1 && m_seq[lead] == 8'hE0) lead++;
      if (m_seq[0] == 8'hE1) begin
         if (n == 8) begin kind = 3; ev = {8'hE1, 2'b00}; end
      end else if (n == 1) begin
         if (last == 8'hE0 || last == 8'hF0) kind = 0;
         else if (last inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) kind = 1;
         else begin kind = 3; ev = {last, 2'b00}; end
      end else if (lead == n - 1) begin
         if (last == 8'hE0 || last == 8'hF0) kind = 0;
         else if (last == 8'h12) kind = 1;
         else if (last == 8'hE1) kind = 2;
         else begin kind = 3; ev = {last, 2'b10}; end
      end else if (n == 2) begin
         if (is_pre(last)) kind = 2;
         else begin kind = 3; ev = {last, 2'b01}; end
      end else begin
         if (is_pre(last)) kind = 2;
         else if (last == 8'h12) kind = 1;
         else begin kind = 3; ev = {last, 2'b11}; end
      end
   endfunction

   // Inputs change only just after posedge, so the falling edge sees exactly
   // what the next rising edge will consume.
   always @(negedge clk) begin
      logic [12:0] exp_v;
      logic [9:0]  head;
      int          kind;
      logic [9:0]  ev;
      bit          push, err, pop;
      if (!rst_n) begin
         m_seq.delete();
         m_q.delete();
         m_gap = 0;
         m_ovf = 1'b0;
         m_err = 1'b0;
         chk("reset outputs", {key_valid, key_code, key_ext, key_break, overflow, seq_err}, 0);
      end else begin
         head  = (m_q.size() > 0) ? m_q[0] : 10'h0;
         exp_v = {m_q.size() > 0, head, m_ovf, m_err};
         chk("cycle outputs", {key_valid, key_code, key_ext, key_break, overflow, seq_err},
             exp_v);
         push = 0;
         err  = 0;
         ev   = '0;
         if (rx_strb) begin
            m_gap = 0;
            m_seq.push_back(rx_data);
            classify(kind, ev);
            if (kind != 0) m_seq.delete();
            err  = (kind == 2);
            push = (kind == 3);
         end else if (m_seq.size() > 0) begin
            m_gap++;
            if (m_gap == TO) begin
               err = 1;
               m_seq.delete();
               m_gap = 0;
            end
         end
         pop = (m_q.size() > 0) && key_ready;
         if (push && m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
         else if (push) m_q.push_back(ev);
         if (pop) void'(m_q.pop_front());
         m_err = err;
      end
   end

   //------------------------------------------------------------------------
   // Stimulus (every task starts and ends 1 time unit after a rising edge)
   //------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_strb = 1'b1;
      step(1);
      rx_strb = 1'b0;
   endtask

   initial begin
      int waited;
      logic [7:0] t3[8];
      logic [7:0] drain[4];

      step(3);
      chk("reset valid", key_valid, 0);
      chk("reset overflow", overflow, 0);
      rst_n = 1'b1;
      step(2);

      // T1: make code, one-cycle latency, popped next cycle
      key_ready = 1'b1;
      send(8'h1C);
      chk("T1 event", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h1C, 2'b00});
      step(1);
      chk("T1 popped", key_valid, 0);

      // T2: extended break, plain break, filler bytes, illegal prefix
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("T2 E0F075", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h75, 2'b11});
      step(1);
      send(8'hF0); send(8'h1C);
      chk("T2 F01C", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h1C, 2'b01});
      step(1);
      send(8'hAA); send(8'hFA);
      chk("T2 filler", key_valid, 0);
      send(8'hF0); send(8'hE0);
      chk("T2 F0E0 err", seq_err, 1);
      step(1);

      // T3: Pause is one event; fake shift dropped
      key_ready = 1'b0;
      t3 = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 7; i++) send(t3[i]);
      chk("T3 pause pending", key_valid, 0);
      send(t3[7]);
      chk("T3 pause event", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'hE1, 2'b00});
      send(8'hE0); send(8'h12);
      key_ready = 1'b1;
      step(1);
      chk("T3 single event", key_valid, 0);

      // T4: timeout aborts prefix; byte on the last cycle beats the timeout
      send(8'hE0);
      waited = 0;
      while (!seq_err && waited < 3 * TO) begin
         step(1);
         waited++;
      end
      chk("T4 timeout latency", waited, TO);
      send(8'h1C);
      chk("T4 prefix lost", {key_valid, key_code, key_ext}, {1'b1, 8'h1C, 1'b0});
      step(1);
      send(8'hE0);
      step(TO - 1);
      send(8'hF0);
      chk("T4 strb beats timeout", seq_err, 0);
      send(8'h75);
      chk("T4 E0F075 kept", {key_code, key_ext, key_break}, {8'h75, 2'b11});
      step(1);

      // T5: fill, push+pop while full, then overflow
      key_ready = 1'b0;
      send(8'h15); send(8'h16); send(8'h1D); send(8'h24);
      key_ready = 1'b1;
      send(8'h2D);
      key_ready = 1'b0;
      chk("T5 full push+pop", {overflow, key_valid, key_code}, {1'b0, 1'b1, 8'h16});
      send(8'h2C);
      chk("T5 overflow", {overflow, key_valid}, 2'b11);
      drain = '{8'h16, 8'h1D, 8'h24, 8'h2D};
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("T5 drain order", key_code, {24'h0, drain[i]});
         step(1);
      end
      chk("T5 fifth lost", key_valid, 0);

      // T6: reset mid-sequence with events queued
      key_ready = 1'b0;
      send(8'h1C); send(8'h21); send(8'hE0);
      rst_n = 1'b0;
      #1;
      chk("T6 async clear", {key_valid, overflow}, 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      key_ready = 1'b1;
      send(8'h75);
      chk("T6 after reset", {key_valid, key_code, key_ext}, {1'b1, 8'h75, 1'b0});
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
